// File: rtl/bnn_mem_pkg.sv
// Shared constants and types for the BNN weight/BN parameter SRAM pair.
package bnn_mem_pkg;

  localparam int WEIGHT_DEPTH  = 512;
  localparam int BN_DEPTH      = 128;
  localparam int WEIGHT_WIDTH  = 8;
  localparam int ADDR_WIDTH    = 9;
  localparam int BN_WIDTH      = 16;
  localparam int BN_ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_W  = 2'd1,
    LOAD_BN = 2'd2,
    FIN     = 2'd3
  } ld_state_t;

endpackage

// File: rtl/weight_load_ctrl.sv
// Write-side sequencer: streams a layer's weights, then its BN words, into the
// write ports of the weight and BN SRAMs and pulses done when they are resident.
module weight_load_ctrl
  import bnn_mem_pkg::*;
#(
  parameter int weight_width  = WEIGHT_WIDTH,
  parameter int addr_width    = ADDR_WIDTH,
  parameter int bn_width      = BN_WIDTH,
  parameter int bn_addr_width = BN_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [addr_width:0]      w_len,
  input  logic [addr_width-1:0]    w_base,
  input  logic [bn_addr_width:0]   bn_len,
  input  logic [bn_addr_width-1:0] bn_base,
  input  logic [bn_width-1:0]      in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     cs1_wr,
  output logic                     we1_wr,
  output logic                     oe1_wr,
  output logic [addr_width-1:0]    addr1_wr,
  output logic [weight_width-1:0]  data1_wr,
  output logic                     cs2_wr,
  output logic                     we2_wr,
  output logic                     oe2_wr,
  output logic [bn_addr_width-1:0] addr2_wr,
  output logic [bn_width-1:0]      data2_wr,
  output logic                     busy,
  output logic                     done
);

  localparam int WLW = addr_width + 1;
  localparam int BLW = bn_addr_width + 1;
  localparam logic [WLW-1:0] W_LIM = WLW'(1 << addr_width);
  localparam logic [BLW-1:0] B_LIM = BLW'(1 << bn_addr_width);

  ld_state_t state, state_next;

  logic [WLW-1:0]           w_len_c, w_len_q, w_cnt;
  logic [BLW-1:0]           bn_len_c, bn_len_q, bn_cnt;
  logic [addr_width-1:0]    w_ptr;
  logic [bn_addr_width-1:0] bn_ptr;
  logic                     w_strobe, bn_strobe;
  logic                     accept, w_last, bn_last;

  assign w_len_c  = (w_len > W_LIM) ? W_LIM : w_len;
  assign bn_len_c = (bn_len > B_LIM) ? B_LIM : bn_len;

  assign in_ready = (state == LOAD_W) || (state == LOAD_BN);
  assign accept   = in_valid & in_ready;
  assign w_last   = (w_cnt == w_len_q - 1'b1);
  assign bn_last  = (bn_cnt == bn_len_q - 1'b1);

  assign busy   = (state != IDLE);
  assign done   = (state == FIN);
  assign cs1_wr = w_strobe;
  assign we1_wr = w_strobe;
  assign oe1_wr = 1'b0;
  assign cs2_wr = bn_strobe;
  assign we2_wr = bn_strobe;
  assign oe2_wr = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (w_len_c != '0)       state_next = LOAD_W;
          else if (bn_len_c != '0) state_next = LOAD_BN;
          else                     state_next = FIN;
        end
      end
      LOAD_W: begin
        if (accept && w_last) state_next = (bn_len_q != '0) ? LOAD_BN : FIN;
      end
      LOAD_BN: begin
        if (accept && bn_last) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address pointers advance per accepted beat and wrap naturally at the SRAM depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_len_q   <= '0;
      bn_len_q  <= '0;
      w_cnt     <= '0;
      bn_cnt    <= '0;
      w_ptr     <= '0;
      bn_ptr    <= '0;
      w_strobe  <= 1'b0;
      bn_strobe <= 1'b0;
      addr1_wr  <= '0;
      data1_wr  <= '0;
      addr2_wr  <= '0;
      data2_wr  <= '0;
    end else begin
      w_strobe  <= 1'b0;
      bn_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w_len_q  <= w_len_c;
            bn_len_q <= bn_len_c;
            w_ptr    <= w_base;
            bn_ptr   <= bn_base;
            w_cnt    <= '0;
            bn_cnt   <= '0;
          end
        end
        LOAD_W: begin
          if (accept) begin
            w_strobe <= 1'b1;
            addr1_wr <= w_ptr;
            data1_wr <= in_data[weight_width-1:0];
            w_ptr    <= w_ptr + 1'b1;
            w_cnt    <= w_cnt + 1'b1;
          end
        end
        LOAD_BN: begin
          if (accept) begin
            bn_strobe <= 1'b1;
            addr2_wr  <= bn_ptr;
            data2_wr  <= in_data;
            bn_ptr    <= bn_ptr + 1'b1;
            bn_cnt    <= bn_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: every accepted beat queues its expected
// SRAM write, and the strobe monitor pops and compares address, data and timing.
module tb_weight_load_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  w_len;
  logic [8:0]  w_base;
  logic [7:0]  bn_len;
  logic [6:0]  bn_base;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        cs1_wr, we1_wr, oe1_wr;
  logic [8:0]  addr1_wr;
  logic [7:0]  data1_wr;
  logic        cs2_wr, we2_wr, oe2_wr;
  logic [6:0]  addr2_wr;
  logic [15:0] data2_wr;
  logic        busy;
  logic        done;

  typedef struct {
    int addr;
    int data;
    int due;
  } wr_t;

  wr_t wq[$];
  wr_t bq[$];
  wr_t w_ent, b_ent;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int w_strobes    = 0;
  int bn_strobes   = 0;
  int done_cnt     = 0;

  weight_load_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .w_len    (w_len),
    .w_base   (w_base),
    .bn_len   (bn_len),
    .bn_base  (bn_base),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cs1_wr   (cs1_wr),
    .we1_wr   (we1_wr),
    .oe1_wr   (oe1_wr),
    .addr1_wr (addr1_wr),
    .data1_wr (data1_wr),
    .cs2_wr   (cs2_wr),
    .we2_wr   (we2_wr),
    .oe2_wr   (oe2_wr),
    .addr2_wr (addr2_wr),
    .data2_wr (data2_wr),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {in_ready, busy, done, cs1_wr, we1_wr, oe1_wr, addr1_wr, data1_wr,
                      cs2_wr, we2_wr, oe2_wr, addr2_wr, data2_wr}, 64'd0);
  endtask

  // Strobe monitor: each write must match the oldest queued beat and land one cycle after it.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("oe_zero", {oe1_wr, oe2_wr}, 0);
      checkOutput("strobe_excl", cs1_wr & cs2_wr, 0);
      if (cs1_wr) begin
        if (wq.size() == 0) checkOutput("w_spurious", cs1_wr, 0);
        else begin
          w_ent = wq.pop_front();
          w_strobes++;
          checkOutput("w_we", we1_wr, 1);
          checkOutput("w_addr", addr1_wr, w_ent.addr);
          checkOutput("w_data", data1_wr, w_ent.data);
          checkOutput("w_time", cyc, w_ent.due);
        end
      end else begin
        checkOutput("w_we_idle", we1_wr, 0);
        if (wq.size() > 0 && wq[0].due <= cyc) checkOutput("w_missing", cs1_wr, 1);
      end
      if (cs2_wr) begin
        if (bq.size() == 0) checkOutput("bn_spurious", cs2_wr, 0);
        else begin
          b_ent = bq.pop_front();
          bn_strobes++;
          checkOutput("bn_we", we2_wr, 1);
          checkOutput("bn_addr", addr2_wr, b_ent.addr);
          checkOutput("bn_data", data2_wr, b_ent.data);
          checkOutput("bn_time", cyc, b_ent.due);
        end
      end else begin
        checkOutput("bn_we_idle", we2_wr, 0);
        if (bq.size() > 0 && bq[0].due <= cyc) checkOutput("bn_missing", cs2_wr, 1);
      end
      if (done) done_cnt++;
    end
  end

  // Runs one layer load; abort_after >= 0 pulls reset after that many accepted beats.
  task automatic applyStimulus(input int wl, input int wb, input int bl, input int bb,
                               input bit gaps, input bit plain, input logic [7:0] first_data,
                               input bit mid_start, input int abort_after);
    int eff_wl, eff_bl, total, k, w0, b0, d0;
    logic [7:0] d;
    eff_wl = (wl > 512) ? 512 : wl;
    eff_bl = (bl > 128) ? 128 : bl;
    total  = eff_wl + eff_bl;
    k      = 0;
    d      = first_data;
    w0     = w_strobes;
    b0     = bn_strobes;
    d0     = done_cnt;

    @(negedge clk);
    checkOutput("idle_ready", in_ready, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
    start   = 1'b1;
    w_len   = 10'(wl);
    w_base  = 9'(wb);
    bn_len  = 8'(bl);
    bn_base = 7'(bb);
    @(negedge clk);
    checkOutput("busy_rise", busy, 1);

    while (k < total) begin
      start = 1'b0;
      checkOutput("load_ready", in_ready, 1);
      checkOutput("load_done", done, 0);
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        if (k < eff_wl) begin
          in_data = plain ? {8'h00, d} : {8'($urandom), d};
          wq.push_back('{addr: (wb + k) % 512, data: int'(d), due: cyc + 1});
        end else begin
          in_data = plain ? {8'h00, d} : 16'($urandom);
          bq.push_back('{addr: (bb + k - eff_wl) % 128, data: int'(in_data), due: cyc + 1});
        end
        d = d + 8'd1;
        k++;
        if (mid_start && k == 2) begin
          start   = 1'b1;
          w_len   = 10'd9;
          w_base  = 9'd400;
          bn_len  = 8'd1;
          bn_base = 7'd0;
        end
        if (abort_after >= 0 && k == abort_after) begin
          @(posedge clk);
          #2;
          rst_n    = 1'b0;
          in_valid = 1'b0;
          #1;
          checkAllZero("abort_async_zero");
          wq.delete();
          bq.delete();
          repeat (2) @(negedge clk);
          checkAllZero("abort_hold_zero");
          rst_n = 1'b1;
          @(negedge clk);
          checkOutput("abort_no_done", done_cnt - d0, 0);
          checkOutput("abort_idle_busy", busy, 0);
          return;
        end
      end
      @(negedge clk);
    end

    start    = 1'b0;
    in_valid = 1'b0;
    checkOutput("done_pulse", done, 1);
    checkOutput("fin_busy", busy, 1);
    checkOutput("fin_ready", in_ready, 0);
    #1;
    checkOutput("w_count", w_strobes - w0, eff_wl);
    checkOutput("bn_count", bn_strobes - b0, eff_bl);
    checkOutput("queues_drained", wq.size() + bq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    w_len    = '0;
    w_base   = '0;
    bn_len   = '0;
    bn_base  = '0;
    in_data  = '0;
    in_valid = 1'b0;
    #3;
    checkAllZero("reset_zero");
    #19;
    rst_n = 1'b1;

    applyStimulus(4, 0, 2, 10, 1'b0, 1'b1, 8'h11, 1'b0, -1);
    applyStimulus(3, 510, 0, 0, 1'b0, 1'b0, 8'h40, 1'b0, -1);
    applyStimulus(8, 100, 0, 0, 1'b1, 1'b0, 8'h80, 1'b0, -1);
    applyStimulus(0, 0, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, -1);
    applyStimulus(600, 7, 0, 0, 1'b0, 1'b0, 8'h01, 1'b0, -1);
    applyStimulus(6, 20, 3, 126, 1'b0, 1'b0, 8'hA0, 1'b1, -1);
    applyStimulus(0, 0, 200, 5, 1'b1, 1'b0, 8'h33, 1'b0, -1);
    applyStimulus(5, 50, 0, 0, 1'b0, 1'b0, 8'hC0, 1'b0, 2);
    applyStimulus(1, 300, 0, 0, 1'b0, 1'b0, 8'h5A, 1'b0, -1);
    applyStimulus(2, 511, 2, 127, 1'b1, 1'b0, 8'hE0, 1'b0, -1);

    @(negedge clk);
    checkOutput("end_idle_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
